// File: rtl/clock_mode_controller.sv
// Button conditioning plus run/adjust sequencing for the digital clock front end.
// Optional auto-repeat of held up/down buttons: define CLOCK_CTRL_AUTOREPEAT_EN.

module clock_mode_debounce #(
  parameter int CYCLES = 4
) (
  input  logic clk,
  input  logic rst,
  input  logic i_raw,
  output logic o_level,
  output logic o_press
);
  localparam int CW = (CYCLES > 2) ? $clog2(CYCLES) : 1;
  localparam logic [CW-1:0] LAST = CW'(CYCLES - 1);

  logic [1:0]    r_sync;
  logic          r_level;
  logic          r_level_d;
  logic [CW-1:0] r_cnt;

  always_ff @(posedge clk) begin
    if (rst) begin
      r_sync    <= 2'b00;
      r_level   <= 1'b0;
      r_level_d <= 1'b0;
      r_cnt     <= '0;
    end else begin
      r_sync    <= {r_sync[0], i_raw};
      r_level_d <= r_level;
      if (r_sync[1] == r_level) begin
        r_cnt <= '0;
      end else if (r_cnt == LAST) begin
        r_level <= r_sync[1];
        r_cnt   <= '0;
      end else begin
        r_cnt <= r_cnt + 1'b1;
      end
    end
  end

  assign o_level = r_level;
  assign o_press = r_level & ~r_level_d;
endmodule

module clock_mode_controller #(
  parameter int DEBOUNCE_CYCLES = 500000,
  parameter int REPEAT_DELAY    = 50000000,
  parameter int REPEAT_RATE     = 10000000
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       tick_1hz,
  input  logic       btn_mode,
  input  logic       btn_up,
  input  logic       btn_down,
  output logic       enable_seconds,
  output logic       adjust_enable_minutes,
  output logic       adjust_enable_hours,
  output logic       Up_down,
  output logic [1:0] mode_led,
  output logic       blink
);
  typedef enum logic [1:0] {
    RUN      = 2'b00,
    ADJ_HOUR = 2'b01,
    ADJ_MIN  = 2'b10,
    BAD      = 2'b11
  } state_t;

  // bit 0 = mode, bit 1 = up, bit 2 = down
  logic [2:0] w_lvl;
  logic [2:0] w_press;

  clock_mode_debounce #(.CYCLES(DEBOUNCE_CYCLES)) u_db [2:0] (
    .clk     (clk),
    .rst     (rst),
    .i_raw   ({btn_down, btn_up, btn_mode}),
    .o_level (w_lvl),
    .o_press (w_press)
  );

  state_t r_state, w_next;
  logic   r_en_sec, r_adj_h, r_adj_m, r_updn, r_blink;
  logic   w_en_sec, w_adj_h, w_adj_m, w_updn, w_blink;

  logic w_mode, w_up_only, w_dn_only, w_adj;
  logic w_rpt_up, w_rpt_dn, w_step_up, w_step_dn;
  logic w_unused;

  assign w_mode    = w_press[0];
  assign w_up_only = w_press[1] & ~w_press[2] & ~w_mode;
  assign w_dn_only = w_press[2] & ~w_press[1] & ~w_mode;
  assign w_adj     = (r_state == ADJ_HOUR) || (r_state == ADJ_MIN);

`ifdef CLOCK_CTRL_AUTOREPEAT_EN
  localparam int RMAX = (REPEAT_DELAY > REPEAT_RATE) ? REPEAT_DELAY : REPEAT_RATE;
  localparam int RW   = $clog2(RMAX + 1);

  logic          r_rpt_act, r_rpt_dir, r_rpt_first;
  logic [RW-1:0] r_rpt_cnt;
  logic          w_rpt_stop, w_rpt_hit;

  // Holding button must stay the only accepted direction, in an adjust state.
  assign w_rpt_stop = ~w_adj | w_mode | (w_lvl[1] & w_lvl[2]) |
                      ~(r_rpt_dir ? w_lvl[1] : w_lvl[2]);
  assign w_rpt_hit  = r_rpt_act & ~w_rpt_stop &
                      (r_rpt_first ? (r_rpt_cnt == RW'(REPEAT_DELAY - 1))
                                   : (r_rpt_cnt == RW'(REPEAT_RATE - 1)));
  assign w_rpt_up   = w_rpt_hit & r_rpt_dir;
  assign w_rpt_dn   = w_rpt_hit & ~r_rpt_dir;
  assign w_unused   = w_lvl[0];

  always_ff @(posedge clk) begin
    if (rst) begin
      r_rpt_act   <= 1'b0;
      r_rpt_dir   <= 1'b1;
      r_rpt_first <= 1'b0;
      r_rpt_cnt   <= '0;
    end else if ((w_up_only | w_dn_only) & w_adj) begin
      r_rpt_act   <= 1'b1;
      r_rpt_dir   <= w_up_only;
      r_rpt_first <= 1'b1;
      r_rpt_cnt   <= '0;
    end else if (r_rpt_act & w_rpt_stop) begin
      r_rpt_act <= 1'b0;
    end else if (w_rpt_hit) begin
      r_rpt_first <= 1'b0;
      r_rpt_cnt   <= '0;
    end else if (r_rpt_act) begin
      r_rpt_cnt <= r_rpt_cnt + 1'b1;
    end
  end
`else
  assign w_rpt_up = 1'b0;
  assign w_rpt_dn = 1'b0;
  assign w_unused = ^{w_lvl, REPEAT_DELAY[0], REPEAT_RATE[0]};
`endif

  assign w_step_up = w_up_only | w_rpt_up;
  assign w_step_dn = w_dn_only | w_rpt_dn;

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state  <= RUN;
      r_en_sec <= 1'b0;
      r_adj_h  <= 1'b0;
      r_adj_m  <= 1'b0;
      r_updn   <= 1'b1;
      r_blink  <= 1'b0;
    end else begin
      r_state  <= w_next;
      r_en_sec <= w_en_sec;
      r_adj_h  <= w_adj_h;
      r_adj_m  <= w_adj_m;
      r_updn   <= w_updn;
      r_blink  <= w_blink;
    end
  end

  always_comb begin
    w_next   = r_state;
    w_en_sec = 1'b0;
    w_adj_h  = 1'b0;
    w_adj_m  = 1'b0;
    w_updn   = r_updn;
    w_blink  = r_blink;
    case (r_state)
      RUN: begin
        w_en_sec = tick_1hz;
        w_updn   = 1'b1;
        w_blink  = 1'b0;
        if (w_mode) w_next = ADJ_HOUR;
      end
      ADJ_HOUR: begin
        if (tick_1hz) w_blink = ~r_blink;
        if (w_mode) begin
          w_next = ADJ_MIN;
        end else if (w_step_up ^ w_step_dn) begin
          w_adj_h = 1'b1;
          w_updn  = w_step_up;
        end
      end
      ADJ_MIN: begin
        if (tick_1hz) w_blink = ~r_blink;
        if (w_mode) begin
          w_next  = RUN;
          w_updn  = 1'b1;
          w_blink = 1'b0;
        end else if (w_step_up ^ w_step_dn) begin
          w_adj_m = 1'b1;
          w_updn  = w_step_up;
        end
      end
      default: begin
        w_next  = RUN;
        w_updn  = 1'b1;
        w_blink = 1'b0;
      end
    endcase
  end

  assign enable_seconds        = r_en_sec;
  assign adjust_enable_hours   = r_adj_h;
  assign adjust_enable_minutes = r_adj_m;
  assign Up_down               = r_updn;
  assign mode_led              = r_state;
  assign blink                 = r_blink;
endmodule

// File: tb/tb_clock_mode_controller.sv
// Directed bench for clock_mode_controller with short debounce/repeat parameters.
`timescale 1ns/1ps
module tb_clock_mode_controller;
  logic clk = 1'b0;
  logic rst, tick_1hz, btn_mode, btn_up, btn_down;
  logic enable_seconds, adjust_enable_minutes, adjust_enable_hours, Up_down, blink;
  logic [1:0] mode_led;
  int checks = 0;
  int failures = 0;

  clock_mode_controller #(.DEBOUNCE_CYCLES(4), .REPEAT_DELAY(20), .REPEAT_RATE(5)) dut (
    .clk(clk), .rst(rst), .tick_1hz(tick_1hz),
    .btn_mode(btn_mode), .btn_up(btn_up), .btn_down(btn_down),
    .enable_seconds(enable_seconds),
    .adjust_enable_minutes(adjust_enable_minutes),
    .adjust_enable_hours(adjust_enable_hours),
    .Up_down(Up_down), .mode_led(mode_led), .blink(blink)
  );

  always #5 clk = ~clk;

  task automatic cyc(input int n);
    for (int i = 0; i < n; i++) begin
      @(posedge clk); #1;
    end
  endtask

  task automatic tick_pulse();
    tick_1hz = 1'b1;
    @(posedge clk); #1;
    tick_1hz = 1'b0;
  endtask

  // Drives the chosen buttons for 'hold' edges and records step pulses over 'win' edges.
  task automatic press_win(input logic m, input logic u, input logic d,
                           input int hold, input int win,
                           output int nh, output int nm, output logic ud,
                           output int first, output int last);
    nh = 0; nm = 0; ud = 1'bx; first = -1; last = -1;
    btn_mode = m; btn_up = u; btn_down = d;
    for (int i = 1; i <= win; i++) begin
      @(posedge clk); #1;
      if (i == hold) begin
        btn_mode = 1'b0; btn_up = 1'b0; btn_down = 1'b0;
      end
      if (adjust_enable_hours) nh++;
      if (adjust_enable_minutes) nm++;
      if (adjust_enable_hours | adjust_enable_minutes) begin
        if (first < 0) first = i;
        last = i;
        ud = Up_down;
      end
    end
  endtask

  task automatic test_reset();
    rst = 1'b1; tick_1hz = 1'b0; btn_mode = 1'b0; btn_up = 1'b0; btn_down = 1'b0;
    cyc(3);
    rst = 1'b0;
    cyc(1);
    checks++; if (mode_led !== 2'b00) begin failures++; $display("FAIL reset_mode_led got=%b exp=00", mode_led); end
    checks++; if (Up_down !== 1'b1) begin failures++; $display("FAIL reset_up_down got=%b exp=1", Up_down); end
    checks++; if ({enable_seconds, adjust_enable_hours, adjust_enable_minutes, blink} !== 4'b0000) begin
      failures++; $display("FAIL reset_outputs got=%b exp=0000",
                           {enable_seconds, adjust_enable_hours, adjust_enable_minutes, blink});
    end
  endtask

  task automatic test_run_ticks();
    for (int k = 0; k < 3; k++) begin
      tick_pulse();
      checks++; if (enable_seconds !== 1'b1) begin failures++; $display("FAIL run_tick%0d_en got=%b exp=1", k, enable_seconds); end
      checks++; if ({adjust_enable_hours, adjust_enable_minutes, mode_led, Up_down} !== 5'b00001) begin
        failures++; $display("FAIL run_tick%0d_others got=%b exp=00001", k,
                             {adjust_enable_hours, adjust_enable_minutes, mode_led, Up_down});
      end
      cyc(1);
      checks++; if (enable_seconds !== 1'b0) begin failures++; $display("FAIL run_tick%0d_width got=%b exp=0", k, enable_seconds); end
      cyc(8);
    end
  endtask

  task automatic test_mode_debounce();
    btn_mode = 1'b1;
    cyc(3);
    btn_mode = 1'b0;
    cyc(10);
    checks++; if (mode_led !== 2'b00) begin failures++; $display("FAIL mode_glitch got=%b exp=00", mode_led); end
    btn_mode = 1'b1;
    for (int i = 1; i <= 10; i++) begin
      cyc(1);
      if (i == 6) begin
        checks++; if (mode_led !== 2'b00) begin failures++; $display("FAIL mode_early got=%b exp=00", mode_led); end
      end
      if (i == 7) begin
        checks++; if (mode_led !== 2'b01) begin failures++; $display("FAIL mode_latency got=%b exp=01", mode_led); end
      end
    end
    btn_mode = 1'b0;
    cyc(10);
    checks++; if (mode_led !== 2'b01) begin failures++; $display("FAIL mode_hold_once got=%b exp=01", mode_led); end
  endtask

  task automatic test_adjust_hour();
    int nh, nm, f, l;
    logic ud;
    press_win(1'b0, 1'b1, 1'b0, 8, 20, nh, nm, ud, f, l);
    checks++; if (nh !== 1 || nm !== 0) begin failures++; $display("FAIL hour_up_count got=%0d/%0d exp=1/0", nh, nm); end
    checks++; if (ud !== 1'b1 || f !== 7) begin failures++; $display("FAIL hour_up_dir got=%b@%0d exp=1@7", ud, f); end
    press_win(1'b0, 1'b0, 1'b1, 8, 20, nh, nm, ud, f, l);
    checks++; if (nh !== 1 || nm !== 0) begin failures++; $display("FAIL hour_dn_count got=%0d/%0d exp=1/0", nh, nm); end
    checks++; if (ud !== 1'b0) begin failures++; $display("FAIL hour_dn_dir got=%b exp=0", ud); end
    checks++; if (Up_down !== 1'b0) begin failures++; $display("FAIL hour_dir_hold got=%b exp=0", Up_down); end
    tick_pulse();
    checks++; if (enable_seconds !== 1'b0) begin failures++; $display("FAIL hour_sec_frozen got=%b exp=0", enable_seconds); end
    checks++; if (blink !== 1'b1) begin failures++; $display("FAIL hour_blink1 got=%b exp=1", blink); end
    cyc(3);
    tick_pulse();
    checks++; if (blink !== 1'b0) begin failures++; $display("FAIL hour_blink2 got=%b exp=0", blink); end
  endtask

  task automatic test_conflicts();
    int nh, nm, f, l;
    logic ud;
    press_win(1'b0, 1'b1, 1'b1, 10, 22, nh, nm, ud, f, l);
    checks++; if (nh !== 0 || nm !== 0) begin failures++; $display("FAIL updown_both got=%0d/%0d exp=0/0", nh, nm); end
    press_win(1'b1, 1'b1, 1'b0, 8, 20, nh, nm, ud, f, l);
    checks++; if (mode_led !== 2'b10) begin failures++; $display("FAIL mode_up_state got=%b exp=10", mode_led); end
    checks++; if (nh !== 0 || nm !== 0) begin failures++; $display("FAIL mode_up_drop got=%0d/%0d exp=0/0", nh, nm); end
  endtask

  task automatic test_adjust_min();
    int nh, nm, f, l;
    logic ud;
    press_win(1'b0, 1'b1, 1'b0, 50, 65, nh, nm, ud, f, l);
`ifdef CLOCK_CTRL_AUTOREPEAT_EN
    checks++; if (nm !== 7 || nh !== 0) begin failures++; $display("FAIL min_repeat_count got=%0d/%0d exp=7/0", nm, nh); end
    checks++; if (f !== 7 || l !== 52) begin failures++; $display("FAIL min_repeat_span got=%0d..%0d exp=7..52", f, l); end
`else
    checks++; if (nm !== 1 || nh !== 0) begin failures++; $display("FAIL min_hold_count got=%0d/%0d exp=1/0", nm, nh); end
    checks++; if (f !== 7) begin failures++; $display("FAIL min_hold_time got=%0d exp=7", f); end
`endif
    checks++; if (ud !== 1'b1) begin failures++; $display("FAIL min_up_dir got=%b exp=1", ud); end
    press_win(1'b0, 1'b0, 1'b1, 8, 20, nh, nm, ud, f, l);
    checks++; if (nm !== 1 || ud !== 1'b0) begin failures++; $display("FAIL min_dn got=%0d dir=%b exp=1 dir=0", nm, ud); end
    tick_pulse();
    checks++; if (blink !== 1'b1) begin failures++; $display("FAIL min_blink got=%b exp=1", blink); end
  endtask

  task automatic test_return_run();
    int nh, nm, f, l;
    logic ud;
    press_win(1'b1, 1'b0, 1'b0, 8, 20, nh, nm, ud, f, l);
    checks++; if (mode_led !== 2'b00) begin failures++; $display("FAIL return_state got=%b exp=00", mode_led); end
    checks++; if (blink !== 1'b0 || Up_down !== 1'b1) begin
      failures++; $display("FAIL return_outputs got blink=%b ud=%b exp blink=0 ud=1", blink, Up_down);
    end
    tick_pulse();
    checks++; if (enable_seconds !== 1'b1) begin failures++; $display("FAIL return_tick got=%b exp=1", enable_seconds); end
  endtask

  task automatic test_reset_mid();
    int nh, nm, f, l;
    logic ud;
    press_win(1'b1, 1'b0, 1'b0, 8, 20, nh, nm, ud, f, l);
    press_win(1'b0, 1'b0, 1'b1, 8, 20, nh, nm, ud, f, l);
    tick_pulse();
    checks++; if ({mode_led, Up_down, blink} !== 4'b0101) begin
      failures++; $display("FAIL pre_reset got=%b exp=0101", {mode_led, Up_down, blink});
    end
    btn_mode = 1'b1;
    cyc(3);
    rst = 1'b1;
    cyc(1);
    rst = 1'b0;
    checks++; if ({mode_led, Up_down, blink, enable_seconds, adjust_enable_hours, adjust_enable_minutes} !== 7'b0010000) begin
      failures++; $display("FAIL mid_reset got=%b exp=0010000",
        {mode_led, Up_down, blink, enable_seconds, adjust_enable_hours, adjust_enable_minutes});
    end
    for (int i = 1; i <= 8; i++) begin
      cyc(1);
      if (i == 6) begin
        checks++; if (mode_led !== 2'b00) begin failures++; $display("FAIL held_reset_early got=%b exp=00", mode_led); end
      end
      if (i == 7) begin
        checks++; if (mode_led !== 2'b01) begin failures++; $display("FAIL held_reset_press got=%b exp=01", mode_led); end
      end
    end
    btn_mode = 1'b0;
    cyc(10);
  endtask

  initial begin
    rst = 1'b1; tick_1hz = 1'b0; btn_mode = 1'b0; btn_up = 1'b0; btn_down = 1'b0;
    @(posedge clk); #1;
    test_reset();
    test_run_ticks();
    test_mode_debounce();
    test_adjust_hour();
    test_conflicts();
    test_adjust_min();
    test_return_run();
    test_reset_mid();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
